// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Responder on the core data-memory bus. A store to TXDATA pushes a byte into
// a small circular FIFO; the TX FSM pops bytes and serialises them LSB first
// as 8N1 frames, each bit lasting DIVISOR+1 clocks.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   dmem_A_i     - byte address from the core
//   dmem_WD_i    - write data
//   dmem_WE_i    - write enable
//   dmem_WMASK_i - byte write mask, bit n qualifies WD[8n+7:8n]
//   dmem_RD_o    - combinational read data, 0 when not selected
//   sel_o        - combinational window hit, A_i[31:4] == BASE_ADDR[31:4]
//   tx_o         - registered serial output, idle high
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dmem_A_i,
    input  logic [31:0] dmem_WD_i,
    input  logic        dmem_WE_i,
    input  logic [3:0]  dmem_WMASK_i,
    output logic [31:0] dmem_RD_o,
    output logic        sel_o,
    output logic        tx_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      div_q, div_d;

    state_e           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic        wr_en;
    logic [1:0]  reg_off;
    logic        fifo_full;
    logic        fifo_empty;
    logic        baud_zero;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] status;

    logic unused_bits;
    assign unused_bits = ^{dmem_WD_i[31:16], dmem_A_i[1:0]};

    assign sel_o      = (dmem_A_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en      = sel_o & dmem_WE_i;
    assign reg_off    = dmem_A_i[3:2];
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign baud_zero  = (baud_q == 16'd0);

    // The FSM pops either from IDLE or at the end of a stop bit; the latter
    // keeps back-to-back frames contiguous.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_zero));

    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted in that case.
    assign push_req = wr_en && (reg_off == 2'd0) && dmem_WMASK_i[0];
    assign push     = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = wr_en && (reg_off == 2'd1) && dmem_WMASK_i[0] && dmem_WD_i[3];

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        // Set takes priority over a simultaneous clear.
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        div_d = div_q;
        if (wr_en && (reg_off == 2'd2)) begin
            if (dmem_WMASK_i[0]) div_d[7:0]  = dmem_WD_i[7:0];
            if (dmem_WMASK_i[1]) div_d[15:8] = dmem_WD_i[15:8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dmem_WD_i[7:0];
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // TX FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_START;
            S_START: if (baud_zero) state_d = S_DATA;
            S_DATA:  if (baud_zero && (bit_q == 3'd7)) state_d = S_STOP;
            S_STOP:  if (baud_zero) state_d = fifo_empty ? S_IDLE : S_START;
        endcase
    end

    // TX FSM: datapath outputs. Every reload samples the live DIVISOR, so a
    // DIVISOR write only affects timing from the next bit boundary.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = div_q;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_zero) begin
                    baud_d = div_q;
                    tx_d   = shift_q[0];
                    bit_d  = 3'd0;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_zero) begin
                    baud_d = div_q;
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_zero) begin
                    if (pop) begin
                        shift_d = fifo_mem[rd_ptr_q];
                        baud_d  = div_q;
                        tx_d    = 1'b0;
                    end else begin
                        tx_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    assign status = {24'd0, 4'(count_q), ovf_q, fifo_empty, fifo_full, state_q != S_IDLE};

    always_comb begin
        dmem_RD_o = 32'd0;
        if (sel_o) begin
            case (reg_off)
                2'd1:    dmem_RD_o = status;
                2'd2:    dmem_RD_o = {16'd0, div_q};
                default: dmem_RD_o = 32'd0;
            endcase
        end
    end

    assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard testbench for uart_tx_mmio
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;
    localparam logic [31:0] IDLE_A = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  wm;
    logic [31:0] rd;
    logic        sel;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_DIV(16'd3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .dmem_A_i    (a),
        .dmem_WD_i   (wd),
        .dmem_WE_i   (we),
        .dmem_WMASK_i(wm),
        .dmem_RD_o   (rd),
        .sel_o       (sel),
        .tx_o        (tx)
    );

    // Expected frame: bits [0, split) last len_a clocks, the rest len_b.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] len_a;
        logic [7:0] len_b;
        logic [3:0] split;
    } frame_t;

    frame_t exp_q[$];
    int     start_cyc[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     starts = 0;
    int     m_div = 3;
    bit     m_ovf = 1'b0;

    always @(posedge clk) cyc++;

    function automatic int blen(input frame_t f, input int b);
        return (b < int'(f.split)) ? int'(f.len_a) : int'(f.len_b);
    endfunction

    // Monitor: decodes tx and compares whole frames against the scoreboard.
    frame_t     cur;
    bit         mon_active = 1'b0;
    bit         spur_seen = 1'b0;
    int         bit_i, samp_i, ferr;
    logic [7:0] rxd;
    logic       eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else begin
            if (!mon_active && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    if (!spur_seen) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_frame: tx low at cycle %0d, required idle high", cyc);
                        spur_seen = 1'b1;
                    end
                end else begin
                    cur = exp_q.pop_front();
                    mon_active = 1'b1;
                    bit_i = 0;
                    samp_i = 0;
                    ferr = 0;
                    rxd = 8'h00;
                    starts++;
                    start_cyc.push_back(cyc);
                end
            end
            if (mon_active) begin
                eb = (bit_i == 0) ? 1'b0 : (bit_i == 9) ? 1'b1 : cur.data[bit_i-1];
                if (tx !== eb) ferr++;
                if (bit_i >= 1 && bit_i <= 8 && samp_i == 0) rxd[bit_i-1] = tx;
                samp_i++;
                if (samp_i == blen(cur, bit_i)) begin
                    samp_i = 0;
                    bit_i++;
                    if (bit_i == 10) begin
                        mon_active = 1'b0;
                        total++;
                        if (ferr != 0) begin
                            bad++;
                            $display("FAIL frame: got data 0x%02h with %0d wrong samples, required data 0x%02h",
                                     rxd, ferr, cur.data);
                        end
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        a = IDLE_A; wd = 32'd0; we = 1'b0; wm = 4'd0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk); #1;
        a = addr; wd = data; wm = mask; we = 1'b1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic s);
        a = addr; we = 1'b0; wm = 4'd0;
        #1;
        d = rd;
        s = sel;
    endtask

    // TXDATA store; the model accepts when fewer than DEPTH bytes are pending.
    task automatic tx_push(input logic [7:0] d, input logic [3:0] mask, input int split, input int lb);
        frame_t f;
        @(negedge clk); #1;
        a = BASE; wd = {$urandom_range(0, 255) << 24, 16'hBEEF, d}; wm = mask; we = 1'b1;
        if (mask[0]) begin
            if (exp_q.size() < DEPTH) begin
                f.data  = d;
                f.len_a = 8'(m_div + 1);
                f.len_b = (split >= 10) ? 8'(m_div + 1) : 8'(lb);
                f.split = 4'(split);
                exp_q.push_back(f);
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        s;
        bus_read(addr, d, s);
        check(name, d, exp);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0", exp_q.size(), budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        s;
        int          w_cyc;
        int          starts_before;
        int          n;
        logic [3:0]  mask;

        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", 32'(tx), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check_reg("reset_status", BASE + 32'h4, 32'h0000_0004);
        check_reg("reset_div", BASE + 32'h8, 32'd3);
        check("reset_tx", 32'(tx), 32'd1);
        check_reg("txdata_read", BASE + 32'h0, 32'd0);
        check_reg("reserved_read", BASE + 32'hC, 32'd0);
        bus_read(BASE + 32'hC, d, s);
        check("sel_in_window", 32'(s), 32'd1);

        // Single frame at DIV=3, latency and BUSY duration
        tx_push(8'h55, 4'h1, 10, 0);
        w_cyc = cyc;
        repeat (40) @(posedge clk);
        #1;
        bus_read(BASE + 32'h4, d, s);
        check("busy_at_40", d & 32'h1, 32'h1);
        @(posedge clk); #1;
        bus_read(BASE + 32'h4, d, s);
        check("busy_at_41", d & 32'h1, 32'h0);
        wait_drain(200);
        check("start_latency", 32'(start_cyc[start_cyc.size()-1] - w_cyc), 32'd1);

        // Back-to-back frames at DIV=0
        bus_write(BASE + 32'h8, 32'd0, 4'h3);
        m_div = 0;
        check_reg("div0", BASE + 32'h8, 32'd0);
        tx_push(8'hA5, 4'h1, 10, 0);
        tx_push(8'h3C, 4'h1, 10, 0);
        wait_drain(100);
        check("b2b_gap", 32'(start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2]), 32'd10);

        // Overflow at DIV=15
        bus_write(BASE + 32'h8, 32'd15, 4'h3);
        m_div = 15;
        m_ovf = 1'b0;
        for (int i = 0; i < 6; i++) tx_push(8'($urandom), 4'h1, 10, 0);
        check("ovf_model", 32'(m_ovf), 32'd1);
        check_reg("status_full_ovf", BASE + 32'h4, 32'h0000_004B);
        bus_write(BASE + 32'h4, 32'h8, 4'h1);
        check_reg("status_ovf_clr", BASE + 32'h4, 32'h0000_0043);
        wait_drain(1200);
        check_reg("status_drained", BASE + 32'h4, 32'h0000_0004);

        // DIVISOR change mid-frame: bit 3 keeps 2 clocks, later bits take 8
        bus_write(BASE + 32'h8, 32'd1, 4'h3);
        m_div = 1;
        tx_push(8'hFF, 4'h1, 5, 8);
        repeat (9) @(posedge clk);
        bus_write(BASE + 32'h8, 32'd7, 4'h3);
        m_div = 7;
        wait_drain(200);

        // Reset mid-DATA
        bus_write(BASE + 32'h8, 32'd3, 4'h3);
        m_div = 3;
        tx_push(8'h0F, 4'h1, 10, 0);
        tx_push(8'h33, 4'h1, 10, 0);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'd1);
        starts_before = starts;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        m_div = 3;
        repeat (60) @(posedge clk);
        #1;
        check("no_frame_after_reset", 32'(starts), 32'(starts_before));
        check_reg("status_after_reset", BASE + 32'h4, 32'h0000_0004);
        check_reg("div_after_reset", BASE + 32'h8, 32'd3);

        // Outside the window and byte-masked DIVISOR writes
        bus_read(BASE + 32'h10, d, s);
        check("oow_sel", 32'(s), 32'd0);
        check("oow_rd", d, 32'd0);
        bus_write(BASE + 32'h18, 32'h0000_FFFF, 4'h3);
        bus_write(BASE + 32'h10, 32'h0000_0041, 4'h1);
        bus_write(BASE + 32'hC, 32'h0000_1234, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        check_reg("oow_div", BASE + 32'h8, 32'd3);
        check_reg("oow_status", BASE + 32'h4, 32'h0000_0004);
        bus_write(BASE + 32'h8, 32'h0000_5A77, 4'b0010);
        check_reg("div_hi_byte", BASE + 32'h8, 32'h0000_5A03);
        bus_write(BASE + 32'h8, 32'h0000_9902, 4'b0001);
        check_reg("div_lo_byte", BASE + 32'h8, 32'h0000_5A02);

        // Randomized traffic
        for (int r = 0; r < 8; r++) begin
            m_div = $urandom_range(0, 4);
            bus_write(BASE + 32'h8, {16'($urandom), 16'(m_div)}, 4'h3);
            check_reg("rand_div", BASE + 32'h8, 32'(m_div));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                mask = ($urandom_range(0, 3) == 0) ? 4'b1110 : (4'($urandom) | 4'b0001);
                if (exp_q.size() < DEPTH) tx_push(8'($urandom), mask, 10, 0);
            end
            wait_drain(400);
        end
        check_reg("final_status", BASE + 32'h4, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus (`dmem_A`/`dmem_WD`/`dmem_WE`/`dmem_WMASK`/`dmem_RD`). Core stores to its address window push bytes into a small TX FIFO. A baud-rate FSM serialises them as 8N1 frames on `tx_o`. It sits beside `dmem` at top level; the top level ORs `RD_o` with `dmem`'s read data using `sel_o`.

## Interface
- `BASE_ADDR`, default `32'h0000_0100`: base of the 16-byte register window, 16-byte aligned.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of 2, at least 2.
- `DEFAULT_DIV`, default 16'd3: reset value of DIVISOR.
- `clk_i`, in, 1: single clock; all state changes on the rising edge.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `dmem_A_i`, in, 32: byte address from the core.
- `dmem_WD_i`, in, 32: write data.
- `dmem_WE_i`, in, 1: write enable.
- `dmem_WMASK_i`, in, 4: byte write mask; bit n qualifies `WD[8n+7:8n]`.
- `dmem_RD_o`, out, 32: combinational read data; 0 when not selected.
- `sel_o`, out, 1: combinational; high when `A_i[31:4] == BASE_ADDR[31:4]`.
- `tx_o`, out, 1: serial output, registered, idle high.

## Operation
Registers, at offset `A_i[3:2]`:
- 0x0 TXDATA
  - A write with `WMASK[0]=1` pushes `WD[7:0]`.
  - If the FIFO is full and no pop occurs on the same edge, the byte is dropped and OVF is set.
  - Reads return 0.
- 0x4 STATUS, read:
  - bit0 BUSY (FSM not IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky).
  - bits[7:4] FIFO count; other bits 0.
  - A write with `WMASK[0]=1` and `WD[3]=1` clears OVF. A clear and a set on the same edge leave OVF=1.
- 0x8 DIVISOR, R/W, 16 bits in `[15:0]`.
  - Byte-wise writes use `WMASK[1:0]`.
  - Reads zero-extend to 32 bits.
  - One bit lasts DIVISOR+1 clocks.
- 0xC is reserved: reads return 0, writes are ignored.
- Reads have no side effects. Writes take effect only when `sel_o & WE_i`.

FIFO:
- Circular buffer with read pointer, write pointer and count.
- A push and a pop on the same edge are both performed; count is unchanged. This applies when full too.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE
  - If the FIFO is non-empty: pop into the shift register, load the baud counter with DIVISOR, drive `tx_o` low, go to START.
- START
  - When the baud counter reaches 0: reload it, drive `tx_o` from shift bit0, set the bit count to 0, go to DATA.
- DATA
  - Each baud-counter expiry advances to the next bit, LSB first.
  - After bit 7 expires, drive `tx_o` high and go to STOP.
- STOP
  - On expiry, if the FIFO is non-empty, pop and go straight to START with `tx_o` low, leaving no idle gap.
  - Otherwise go to IDLE.
- A baud counter reload always samples the current DIVISOR. A DIVISOR write mid-frame therefore changes timing only from the next bit boundary.

## Timing
- Reset values:
  - `tx_o`=1, FSM=IDLE, FIFO empty (count 0), OVF=0, DIVISOR=DEFAULT_DIV.
  - `dmem_RD_o` and `sel_o` are combinational from the address.
- Reset mid-frame forces `tx_o` high immediately and discards the FIFO contents.
- Latency: a TXDATA write at edge N gives `tx_o` low from edge N+1, the start of the start bit.
- Frame length is 10×(DIVISOR+1) clocks. Back-to-back frames are contiguous.
- STATUS reflects the state registered at the last edge. A push at edge N is visible in count from edge N.

## Test plan
- Reset, then read STATUS -> 0x0000_0004 (EMPTY only); DIVISOR reads 3; `tx_o`=1.
- DIV=3, write 0x55 to TXDATA -> `tx_o` shows 4 cycles low, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 4 high. BUSY drops after 40 cycles.
- DIV=0, write 0xA5 then 0x3C on consecutive cycles -> two contiguous 10-cycle frames with no idle gap between the stop bit and the second start bit.
- FIFO_DEPTH=4, DIV=15, write 6 bytes in 6 cycles:
  - 1st byte popped at once, next 4 queued, 6th dropped.
  - STATUS = FULL|OVF|BUSY with count 4.
  - Writing STATUS with WD=0x8 clears OVF.
- Write DIVISOR=7 while byte 0xFF is mid-frame at DIV=1 -> the current bit keeps 2 cycles; later bits last 8 cycles.
- Assert `rst_ni` low mid-DATA -> `tx_o`=1 asynchronously; after release, STATUS=0x4 and no further frame is sent.
- Access address BASE+0x10 -> `sel_o`=0, `RD_o`=0, and writes do not change any register.
